// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types, RISC-V opcode constants and redirect helper
//   state_t       : control hazard FSM state (IDLE / FLUSH)
//   OP_*          : major opcodes of the control-transfer instructions
//   redirect_req  : taken branch or unconditional jump resolved in EX
package pipeline_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic redirect_req(input logic branch, input logic cond, input logic jump);
        return jump | (branch & cond);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous up-counter that saturates at all-ones
//   clk   : clock, rising edge
//   clear : synchronous clear, dominates inc
//   inc   : add one unless already saturated
//   value : current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (clear)
            value <= '0;
        else if (inc && !(&value))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/control_hazard_unit.sv
// control_hazard_unit: redirects fetch on taken branches/jumps and squashes wrong-path work
//   CLK, RESET    : clock and synchronous active-high reset
//   Branch_EX, BranchCond_EX, Jump_EX, Target_EX : control transfer resolved in EX
//   PCWrite       : pipeline advance permission (0 = load-use stall)
//   PCSrc         : select PCTarget as next PC
//   PCTarget      : registered redirect address
//   ControlBubble, IF_IDFlush, Busy : asserted for the whole squash window
//   TakenCount    : saturating count of accepted redirects
module control_hazard_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Branch_EX,
    input  logic             BranchCond_EX,
    input  logic             Jump_EX,
    input  logic [31:0]      Target_EX,
    input  logic             PCWrite,
    output logic             PCSrc,
    output logic [31:0]      PCTarget,
    output logic             ControlBubble,
    output logic             IF_IDFlush,
    output logic             Busy,
    output logic [CNT_W-1:0] TakenCount
);

    import pipeline_pkg::*;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state;
    logic [2:0]  squash;
    logic        pcsrc_q;
    logic [31:0] target_q;
    logic        accept;

    // requests seen while squashing belong to the wrong path and are dropped
    assign accept = (state == IDLE) && redirect_req(Branch_EX, BranchCond_EX, Jump_EX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            squash   <= '0;
            pcsrc_q  <= 1'b0;
            target_q <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                state    <= FLUSH;
                squash   <= FLUSH_INIT;
                pcsrc_q  <= 1'b1;
                target_q <= Target_EX;
            end
        end else if (PCWrite) begin
            // only advancing cycles consume the window; stalls freeze everything
            pcsrc_q <= 1'b0;
            squash  <= squash - 3'd1;
            if (squash == 3'd1)
                state <= IDLE;
        end
    end

    assign PCSrc         = pcsrc_q;
    assign PCTarget      = target_q;
    assign Busy          = (state == FLUSH);
    assign ControlBubble = Busy;
    assign IF_IDFlush    = Busy;

    sat_counter #(.WIDTH(CNT_W)) u_taken (
        .clk   (CLK),
        .clear (RESET),
        .inc   (accept),
        .value (TakenCount)
    );

endmodule

// File: tb/tb_control_hazard_unit.sv
// tb_control_hazard_unit: scoreboard bench for control_hazard_unit (32-bit and 4-bit counters)
module tb_control_hazard_unit;

    typedef struct {
        logic        pcsrc;
        logic [31:0] target;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0, cond = 1'b0, jmp = 1'b0, pcw = 1'b1;
    logic [31:0] tgt = '0;

    logic        pcsrc_a, bub_a, fl_a, busy_a;
    logic [31:0] target_a, cnt_a;
    logic        pcsrc_b, bub_b, fl_b, busy_b;
    logic [31:0] target_b;
    logic [3:0]  cnt_b;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    control_hazard_unit dut (
        .CLK(clk), .RESET(rst), .Branch_EX(br), .BranchCond_EX(cond), .Jump_EX(jmp),
        .Target_EX(tgt), .PCWrite(pcw), .PCSrc(pcsrc_a), .PCTarget(target_a),
        .ControlBubble(bub_a), .IF_IDFlush(fl_a), .Busy(busy_a), .TakenCount(cnt_a)
    );

    control_hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .CLK(clk), .RESET(rst), .Branch_EX(br), .BranchCond_EX(cond), .Jump_EX(jmp),
        .Target_EX(tgt), .PCWrite(pcw), .PCSrc(pcsrc_b), .PCTarget(target_b),
        .ControlBubble(bub_b), .IF_IDFlush(fl_b), .Busy(busy_b), .TakenCount(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: outputs are registered, so sample shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pcsrc",     {31'b0, pcsrc_a}, {31'b0, e.pcsrc});
            chk("pctarget",  target_a,         e.target);
            chk("bubble",    {31'b0, bub_a},   {31'b0, e.busy});
            chk("ifid_flush",{31'b0, fl_a},    {31'b0, e.busy});
            chk("busy",      {31'b0, busy_a},  {31'b0, e.busy});
            chk("count32",   cnt_a,            e.cnt);
            chk("pcsrc_w4",  {31'b0, pcsrc_b}, {31'b0, e.pcsrc});
            chk("busy_w4",   {31'b0, busy_b},  {31'b0, e.busy});
            chk("count4",    {28'b0, cnt_b},   (e.cnt > 32'd15) ? 32'd15 : e.cnt);
        end
    end

    // drive one cycle of inputs and queue the outputs expected after that edge
    task automatic cyc(input logic r, input logic b, input logic c, input logic j,
                       input logic [31:0] t, input logic w,
                       input logic ep, input logic [31:0] et, input logic eb, input logic [31:0] ec);
        exp_t e;
        @(negedge clk);
        rst = r; br = b; cond = c; jmp = j; tgt = t; pcw = w;
        e.pcsrc = ep; e.target = et; e.busy = eb; e.cnt = ec;
        q.push_back(e);
    endtask

    initial begin
        int budget;
        // reset, including a redirect that reset must override
        cyc(1, 0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0);
        cyc(1, 0, 0, 1, 32'hDEAD, 1, 0, 32'h0,   0, 0);
        // taken branch: one-cycle redirect, two-cycle squash
        cyc(0, 1, 1, 0, 32'h40,   1, 1, 32'h40,  1, 1);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h40,  1, 1);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h40,  0, 1);
        // not-taken branch and condition without branch: no redirect
        cyc(0, 1, 0, 0, 32'h80,   1, 0, 32'h40,  0, 1);
        cyc(0, 0, 1, 0, 32'h84,   1, 0, 32'h40,  0, 1);
        // jump, then three stall cycles inside the window
        cyc(0, 0, 0, 1, 32'h100,  1, 1, 32'h100, 1, 2);
        cyc(0, 0, 0, 0, 32'h0,    0, 1, 32'h100, 1, 2);
        cyc(0, 0, 0, 0, 32'h0,    0, 1, 32'h100, 1, 2);
        cyc(0, 0, 0, 0, 32'h0,    0, 1, 32'h100, 1, 2);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h100, 1, 2);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h100, 0, 2);
        // wrong-path jumps during the window are ignored
        cyc(0, 0, 0, 1, 32'h100,  1, 1, 32'h100, 1, 3);
        cyc(0, 0, 0, 1, 32'h200,  1, 0, 32'h100, 1, 3);
        cyc(0, 0, 0, 1, 32'h200,  1, 0, 32'h100, 0, 3);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h100, 0, 3);
        // redirect accepted while ID is stalled
        cyc(0, 1, 1, 0, 32'h44,   0, 1, 32'h44,  1, 4);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h44,  1, 4);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h44,  0, 4);
        // reset in the first FLUSH cycle aborts the window
        cyc(0, 0, 0, 1, 32'h500,  1, 1, 32'h500, 1, 5);
        cyc(1, 0, 0, 1, 32'h600,  1, 0, 32'h0,   0, 0);
        cyc(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0);
        // 17 back-to-back jumps: 4-bit counter saturates at 15
        for (int i = 1; i <= 17; i++) begin
            cyc(0, 0, 0, 1, 32'(i * 4), 1, 1, 32'(i * 4), 1, 32'(i));
            cyc(0, 0, 0, 1, 32'hBAD0,   1, 0, 32'(i * 4), 1, 32'(i));
            cyc(0, 0, 0, 1, 32'hBAD4,   1, 0, 32'(i * 4), 0, 32'(i));
        end
        cyc(0, 0, 0, 0, 32'h0, 1, 0, 32'd68, 0, 17);
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #5;
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_hazard_unit.md
CONTROL_HAZARD_UNIT -- requirements
Module: control_hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of squash cycles per redirect; legal range is 1..7.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the redirect statistics counter.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Branch_EX, input, 1 bit: a conditional branch occupies EX.
REQ-006 SHALL have port BranchCond_EX, input, 1 bit: the branch condition evaluated true in EX.
REQ-007 SHALL have port Jump_EX, input, 1 bit: JAL/JALR occupies EX.
REQ-008 SHALL have port Target_EX, input, 32 bits: the resolved redirect address from EX.
REQ-009 SHALL have port PCWrite, input, 1 bit: pipeline advance permission from the load-use hazard logic (0 = stall).
REQ-010 SHALL have port PCSrc, output, 1 bit: selects PCTarget as next PC.
REQ-011 SHALL have port PCTarget, output, 32 bits: the registered redirect address.
REQ-012 SHALL have port ControlBubble, output, 1 bit: forces the ID control word to zero (bubble), consumed by the hazard unit.
REQ-013 SHALL have port IF_IDFlush, output, 1 bit: clears the IF/ID register to a NOP.
REQ-014 SHALL have port Busy, output, 1 bit: the block is in the FLUSH state.
REQ-015 SHALL have port TakenCount, output, CNT_W bits: the number of accepted redirects.

Function
REQ-016 SHALL define redirect request as Jump_EX OR (Branch_EX AND BranchCond_EX).
REQ-017 SHALL implement two states: IDLE and FLUSH.
REQ-018 In IDLE, a redirect request in cycle t SHALL capture Target_EX into PCTarget, load the squash counter with FLUSH_CYCLES, and enter FLUSH at t+1.
REQ-019 In FLUSH, ControlBubble, IF_IDFlush and Busy SHALL be 1; in IDLE they SHALL be 0.
REQ-020 PCSrc SHALL be 1 from the first FLUSH cycle until a cycle with PCWrite=1 occurs, then 0 for the remainder of the window.
REQ-021 The squash counter SHALL decrement only in FLUSH cycles with PCWrite=1; a stall freezes it and all outputs.
REQ-022 When the counter is 1 and PCWrite=1, the block SHALL return to IDLE next cycle; total squash is exactly FLUSH_CYCLES advancing cycles.
REQ-023 Redirect requests arriving in FLUSH SHALL be ignored (wrong-path), with no capture and no count.
REQ-024 A redirect request with PCWrite=0 in IDLE SHALL still be accepted (resolution in EX is independent of the ID stall).
REQ-025 TakenCount SHALL increment by 1 on each accepted redirect and saturate at all-ones without wrap.
REQ-026 PCTarget SHALL hold its value outside the capture cycle.
REQ-027 There SHALL be no combinational path from inputs to outputs; redirect latency is exactly 1 cycle.

Reset
REQ-028 RESET=1 at a clock edge SHALL force IDLE, counter 0, PCSrc=0, PCTarget=0, ControlBubble=0, IF_IDFlush=0, Busy=0 and TakenCount=0, overriding any simultaneous redirect.
REQ-029 Reset asserted mid-FLUSH SHALL abort the window; the first post-reset cycle is IDLE.

Structure
REQ-030 The state enum (IDLE/FLUSH) and the RISC-V opcode constants (BRANCH 7'b1100011, JALR 7'b1100111, JAL 7'b1101111) SHALL live in shared package pipeline_pkg.
REQ-031 The statistics counter SHALL be a sub-module sat_counter (parameter width; ports inc, clear, value).

Verification
REQ-032 Reset, then Branch_EX=1, BranchCond_EX=1, Target_EX=0x0000_0040, PCWrite=1 -> next cycle PCSrc=1 and PCTarget=0x40; ControlBubble=IF_IDFlush=1 for 2 cycles; TakenCount=1.
REQ-033 Branch_EX=1, BranchCond_EX=0 -> all outputs stay 0 and TakenCount is unchanged.
REQ-034 Jump_EX=1 with Target 0x100, then PCWrite=0 for 3 cycles during FLUSH -> PCSrc is held through the stall; FLUSH lasts 2+3=5 cycles.
REQ-035 Second Jump_EX during FLUSH with Target 0x200 -> ignored; PCTarget stays 0x100 and TakenCount increments once only.
REQ-036 RESET asserted in the first FLUSH cycle -> all outputs 0 next cycle; CNT_W=4 with 17 redirects -> TakenCount=15.
